fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's FIFO.
- Accepts a burst request and drives the FIFO read enable, pacing reads so nothing is lost.
- Captures the FIFO's registered read data, one cycle after each enable.
- Re-presents the words on a valid/ready stream with a last-word marker.
- Sits between the FIFO read port and downstream packet logic, in the read clock domain.

Parameters:
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 16, words per burst; legal range 1..256.
- CNT_WIDTH, 8, burst counter width; must satisfy 2**CNT_WIDTH >= BURST_LEN.

Ports:
- clk_read  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle burst request; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse in the cycle the last word is accepted downstream.
- fifo_empty  in  1  FIFO empty flag. Valid each cycle, already reflecting a read issued in the previous cycle.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final word of a burst.
- word_count  out  16  words delivered since reset (see Optional Feature).

Behaviour:
- Reset (rst high at a clk_read edge):
  - state=IDLE; busy, done, fifo_rd_en, m_valid and m_last are 0; m_data=0.
  - Skid buffer is emptied, issue/deliver counters are 0, in-flight flag is cleared.
- Reset mid-burst abandons the burst. A FIFO word returning in the cycle after reset is discarded. No done pulse.
- State machine:
  - IDLE: start=1 -> READ. Counters clear; busy=1 next cycle.
  - READ: fifo_rd_en is combinational = !fifo_empty && (buf_count + inflight < 2) && (issued < BURST_LEN). When issued reaches BURST_LEN -> DRAIN.
  - DRAIN: no reads. When the last word handshakes (m_valid && m_ready && m_last), pulse done -> IDLE. busy drops in the same cycle done is high.
- Read pacing:
  - inflight is a registered copy of fifo_rd_en.
  - fifo_data is written into the 2-entry skid buffer when inflight=1.
  - The occupancy rule guarantees the buffer never overflows.
- Stream rules:
  - m_valid=1 whenever the buffer is non-empty; m_data/m_last come from the head entry.
  - m_data/m_last stay stable while m_valid && !m_ready.
  - Pop on m_valid && m_ready. Push and pop in the same cycle keep the count unchanged.
- m_last is set on the entry whose delivered index equals BURST_LEN-1.
- Latency:
  - fifo_rd_en in cycle N -> word in buffer at N+1 -> m_valid at N+1 if the buffer was empty.
  - Sustained throughput is 1 word/cycle with m_ready=1 and the FIFO non-empty.
- FIFO empty mid-burst: reads stall and the burst resumes when fifo_empty drops. There is no timeout.
- m_ready low: at most 2 words are buffered; reads stall until space frees.
- BURST_LEN=1: a single read, and m_last accompanies the first word.
- start while busy is ignored. start in the same cycle as done is ignored; accepted the next cycle.

Optional Feature:
- Macro FIFO_BURST_READER_STATS_EN.
- Defined: word_count is a 16-bit register incremented on each stream handshake. It wraps 0xFFFF->0 and is cleared by rst.
- Undefined: word_count is tied to 0 and no counter logic is built.

Decomposition:
- Package fifo_reader_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - the localparam SKID_DEPTH=2;
  - the stats counter width constant (16).
- Sub-module fifo_reader_skid: 2-entry buffer holding {last, data} with push/pop/count. Instantiated once; the FSM and pacing stay in the top.

Test Plan:
- FIFO preloaded with 16 words 0x00..0x0F, m_ready=1, start pulse -> fifo_rd_en high for 16 consecutive cycles. m_data 0x00..0x0F on consecutive cycles; m_last with 0x0F; done one cycle later than... done in the 0x0F handshake cycle; busy then 0.
- Same preload, m_ready toggling 1,0,1,0 -> all 16 words delivered in order with no duplicate or drop. fifo_rd_en never issued while buf_count+inflight=2.
- FIFO holds 5 words; the remaining 11 are written 20 cycles later -> reads stall at 5 words, m_valid drops after word 0x04. The burst resumes; 16 words total; single done.
- rst asserted for one cycle after 7 words are delivered, with one word in flight -> next cycle all outputs 0 and the in-flight word is discarded. A new start delivers a fresh 16-word burst from the FIFO's current head.
- BURST_LEN=1, start while busy and start coincident with done -> exactly one word with m_last=1 per accepted start; ignored starts produce no reads.
- FIFO_BURST_READER_STATS_EN defined, two 16-word bursts -> word_count=32. With the macro undefined, word_count stays 0.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_e     : burst controller states
//   SKID_DEPTH  : entries in the output skid buffer
//   STATS_WIDTH : width of the delivered-word statistics counter
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  localparam int unsigned SKID_DEPTH  = 2;
  localparam int unsigned STATS_WIDTH = 16;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer holding {last, data} words for the burst reader.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/din_i : word arriving from the FIFO this cycle
//   pop_i        : downstream accepts the head word this cycle
//   dout_o       : head word (zero when nothing is available)
//   valid_o      : a word is available (stored or arriving)
//   count_o      : number of stored entries (0..2)
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             empty;
  logic             store;
  logic             drop;

  assign empty = (count_q == 2'd0);
  // A word arriving into an empty buffer is presented the same cycle; it is
  // only stored if downstream does not take it immediately.
  assign store   = push_i && !(empty && pop_i);
  assign drop    = pop_i && !empty;
  assign valid_o = !empty || push_i;
  assign count_o = count_q;

  always_comb begin
    if (!empty)      dout_o = mem_q[rd_ptr_q];
    else if (push_i) dout_o = din_i;
    else             dout_o = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (drop) rd_ptr_q <= !rd_ptr_q;
      case ({store, drop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader for the FIFO read port: on start, issues BURST_LEN paced reads,
// captures the registered read data and re-presents it on a valid/ready stream
// with a last-word marker.
//   clk_read, rst         : clock, synchronous active-high reset
//   start, busy, done     : burst request / in progress / last word accepted
//   fifo_empty, fifo_rd_en, fifo_data : FIFO read port (data one cycle after rd_en)
//   m_data, m_valid, m_ready, m_last  : output stream
//   word_count            : words delivered since reset
// Optional macro FIFO_BURST_READER_STATS_EN builds the word_count counter;
// without it word_count is tied to zero.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                   clk_read,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [STATS_WIDTH-1:0] word_count
);

  // One extra bit so the counters can hold BURST_LEN itself.
  localparam logic [CNT_WIDTH:0] LEN      = (CNT_WIDTH+1)'(BURST_LEN);
  localparam logic [CNT_WIDTH:0] LAST_IDX = (CNT_WIDTH+1)'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_WIDTH:0]  issued_q, issued_d;
  logic [CNT_WIDTH:0]  rx_q, rx_d;
  logic                inflight_q;
  logic [1:0]          buf_count;
  logic [2:0]          occupancy;
  logic [DATA_WIDTH:0] push_word;
  logic [DATA_WIDTH:0] head;
  logic                pop;

  always_ff @(posedge clk_read) begin
    if (rst) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      rx_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      rx_q       <= rx_d;
      inflight_q <= fifo_rd_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    rx_d     = rx_q;
    if (fifo_rd_en) issued_d = issued_q + 1'b1;
    if (inflight_q) rx_d = rx_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          issued_d = '0;
          rx_d     = '0;
        end
      end
      READ:    if (fifo_rd_en && (issued_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Words held plus the word already requested must never exceed the buffer.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q};

  always_comb begin
    fifo_rd_en = (state_q == READ) && !fifo_empty && (occupancy < 3'd2) && (issued_q < LEN);
    done       = (state_q == DRAIN) && pop && head[DATA_WIDTH];
    busy       = (state_q != IDLE) && !done;
  end

  assign push_word = {(rx_q == LAST_IDX), fifo_data};

  fifo_reader_skid #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i  (clk_read),
    .rst_i  (rst),
    .push_i (inflight_q),
    .din_i  (push_word),
    .pop_i  (pop),
    .dout_o (head),
    .valid_o(m_valid),
    .count_o(buf_count)
  );

  assign pop    = m_valid && m_ready;
  assign m_data = head[DATA_WIDTH-1:0];
  assign m_last = head[DATA_WIDTH];

`ifdef FIFO_BURST_READER_STATS_EN
  logic [STATS_WIDTH-1:0] word_count_q;

  always_ff @(posedge clk_read) begin
    if (rst)      word_count_q <= '0;
    else if (pop) word_count_q <= word_count_q + 1'b1;
  end

  assign word_count = word_count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic        busy, done, fifo_empty, fifo_rd_en, m_valid, m_last;
  logic [7:0]  fifo_data = '0, m_data;
  logic [15:0] word_count;

  logic        start1 = 1'b0, m_ready1 = 1'b1, fifo_empty1 = 1'b0;
  logic        busy1, done1, rd1, m_valid1, m_last1;
  logic [7:0]  fifo_data1 = '0, m_data1, ctr1 = '0;
  logic [15:0] word_count1;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [512];
  int wp = 0, rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) if (fifo_rd_en && (wp != rp)) begin fifo_data <= mem[rp]; rp <= rp + 1; end
  always @(posedge clk) if (rd1) begin fifo_data1 <= ctr1; ctr1 <= ctr1 + 8'd1; end

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(8)) u_dut (
    .clk_read(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .word_count(word_count));

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(1)) u_dut1 (
    .clk_read(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .fifo_empty(fifo_empty1), .fifo_rd_en(rd1), .fifo_data(fifo_data1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1),
    .word_count(word_count1));

  // Scoreboards: {last, data}
  logic [8:0] exp_q[$];
  logic [8:0] q1[$];
  int hs_total = 0, done_cnt = 0, stored_tb = 0, infl_tb = 0;
  int rd1_cnt = 0, done1_cnt = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst !== 1'b0) begin
      stored_tb = 0; infl_tb = 0; hs_total = 0;
    end else begin
      checks++;
      if (m_valid !== (stored_tb + infl_tb > 0)) begin
        errors++; $display("FAIL m_valid: got %b want %b", m_valid, (stored_tb + infl_tb > 0));
      end
      if (fifo_rd_en === 1'b1) begin
        checks++;
        if (stored_tb + infl_tb >= 2 || fifo_empty) begin
          errors++; $display("FAIL pacing: rd_en with held=%0d empty=%b, want held<2 and not empty", stored_tb + infl_tb, fifo_empty);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream: got unexpected word %h, want none", {m_last, m_data});
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++; $display("FAIL stream: got last/data %h want %h", {m_last, m_data}, e);
          end
        end
        hs_total++;
      end
      checks++;
      if (done !== (m_valid && m_ready && m_last)) begin
        errors++; $display("FAIL done_pulse: got %b want %b", done, (m_valid && m_ready && m_last));
      end
      if (done === 1'b1) done_cnt++;
      stored_tb = stored_tb + infl_tb - ((m_valid && m_ready) ? 1 : 0);
      infl_tb = (fifo_rd_en === 1'b1) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst === 1'b0) begin
      if (rd1 === 1'b1) rd1_cnt++;
      if (done1 === 1'b1) done1_cnt++;
      if (m_valid1 && m_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL len1_stream: got unexpected word %h, want none", {m_last1, m_data1});
        end else begin
          e = q1.pop_front();
          if ({m_last1, m_data1} !== e) begin
            errors++; $display("FAIL len1_stream: got %h want %h", {m_last1, m_data1}, e);
          end
        end
      end
    end
  end

  task automatic run_until_done(input int max_cyc, input logic toggle, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (toggle) m_ready = ~m_ready;
      @(negedge clk); #1;
      if (done === 1'b1) begin cyc = i; break; end
    end
    checks++;
    if (cyc < 0) begin errors++; $display("FAIL done_timeout: got no done in %0d cycles, want done", max_cyc); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks += 7;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0)     begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    if (m_data !== 8'h00)    begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
  endtask

  task automatic test_basic_burst();
    int first = -1, last = -1, n = 0, dcyc = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      mem[wp] = 8'(i); wp++;
      exp_q.push_back({(i == 15), 8'(i)});
    end
    m_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); #1;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      if (fifo_rd_en === 1'b1) begin if (first < 0) first = c; last = c; n++; end
      if (done === 1'b1) begin
        dcyc = c; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
      end
    end
    checks += 5;
    if (first != 1)  begin errors++; $display("FAIL basic_first_rd: got cycle %0d want 1", first); end
    if (last != 16)  begin errors++; $display("FAIL basic_last_rd: got cycle %0d want 16", last); end
    if (n != 16)     begin errors++; $display("FAIL basic_rd_count: got %0d want 16", n); end
    if (dcyc != 17)  begin errors++; $display("FAIL basic_done_cycle: got %0d want 17", dcyc); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: got %0d words want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int cyc, d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      mem[wp] = 8'(i); wp++;
      exp_q.push_back({(i == 15), 8'(i)});
    end
    m_ready = 1'b1; start = 1'b1;
    run_until_done(80, 1'b1, cyc);
    @(posedge clk); #1; m_ready = 1'b1;
    @(negedge clk); #1;
    checks += 4;
    if (exp_q.size() != 0)   begin errors++; $display("FAIL bp_leftover: got %0d words want 0", exp_q.size()); end
    if (done_cnt - d0 != 1)  begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); end
    if (hs_total != 32)      begin errors++; $display("FAIL bp_handshakes: got %0d want 32", hs_total); end
`ifdef FIFO_BURST_READER_STATS_EN
    if (word_count !== 16'd32) begin errors++; $display("FAIL stats_count: got %0d want 32", word_count); end
`else
    if (word_count !== 16'd0)  begin errors++; $display("FAIL stats_count: got %0d want 0", word_count); end
`endif
  endtask

  task automatic test_fifo_empty_stall();
    int hs0, d0;
    hs0 = hs_total; d0 = done_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(32'h20 + i)});
    for (int i = 0; i < 5; i++) begin mem[wp] = 8'(32'h20 + i); wp++; end
    m_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1; start = 1'b0;
      if (c == 20) for (int i = 5; i < 16; i++) begin mem[wp] = 8'(32'h20 + i); wp++; end
      @(negedge clk); #1;
      if (c == 15) begin
        checks += 4;
        if (m_valid !== 1'b0)    begin errors++; $display("FAIL stall_m_valid: got %b want 0", m_valid); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b want 0", fifo_rd_en); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
        if (hs_total - hs0 != 5) begin errors++; $display("FAIL stall_words: got %0d want 5", hs_total - hs0); end
      end
    end
    checks += 3;
    if (hs_total - hs0 != 16) begin errors++; $display("FAIL stall_total: got %0d want 16", hs_total - hs0); end
    if (done_cnt - d0 != 1)   begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int hs0, n, cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin mem[wp] = 8'(32'h40 + i); wp++; end
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(32'h40 + i)});
    hs0 = hs_total; n = 0;
    m_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 40 && n < 7; c++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); #1;
      n = hs_total - hs0;
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL rstmid_pre_words: got %0d want 7", n); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    checks += 7;
    if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0)     begin errors++; $display("FAIL rstmid_m_last: got %b want 0", m_last); end
    if (m_data !== 8'h00)    begin errors++; $display("FAIL rstmid_m_data: got %h want 00", m_data); end
    if (word_count !== 16'd0) begin errors++; $display("FAIL rstmid_word_count: got %0d want 0", word_count); end
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got m_valid %b want 0", m_valid); end
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), mem[rp + i]});
    @(posedge clk); #1; start = 1'b1;
    run_until_done(40, 1'b0, cyc);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_burst_len_one();
    q1.push_back({1'b1, 8'h00});
    q1.push_back({1'b1, 8'h01});
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1; start1 = (c <= 3);
      @(negedge clk); #1;
      case (c)
        1: begin
          checks += 2;
          if (busy1 !== 1'b1) begin errors++; $display("FAIL len1_busy: got %b want 1", busy1); end
          if (rd1 !== 1'b1)   begin errors++; $display("FAIL len1_rd_first: got %b want 1", rd1); end
        end
        2: begin
          checks++;
          if (done1 !== 1'b1) begin errors++; $display("FAIL len1_done_first: got %b want 1", done1); end
        end
        3: begin
          checks += 2;
          if (rd1 !== 1'b0)   begin errors++; $display("FAIL len1_start_with_done: got rd %b want 0", rd1); end
          if (busy1 !== 1'b0) begin errors++; $display("FAIL len1_idle: got busy %b want 0", busy1); end
        end
        4: begin
          checks++;
          if (rd1 !== 1'b1)   begin errors++; $display("FAIL len1_rd_second: got %b want 1", rd1); end
        end
        5: begin
          checks++;
          if (done1 !== 1'b1) begin errors++; $display("FAIL len1_done_second: got %b want 1", done1); end
        end
        default: ;
      endcase
    end
    start1 = 1'b0;
    checks += 4;
    if (rd1_cnt != 2)   begin errors++; $display("FAIL len1_reads: got %0d want 2", rd1_cnt); end
    if (done1_cnt != 2) begin errors++; $display("FAIL len1_dones: got %0d want 2", done1_cnt); end
    if (q1.size() != 0) begin errors++; $display("FAIL len1_leftover: got %0d want 0", q1.size()); end
`ifdef FIFO_BURST_READER_STATS_EN
    if (word_count1 !== 16'd2) begin errors++; $display("FAIL len1_stats: got %0d want 2", word_count1); end
`else
    if (word_count1 !== 16'd0) begin errors++; $display("FAIL len1_stats: got %0d want 0", word_count1); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_fifo_empty_stall();
    test_reset_mid_burst();
    test_burst_len_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
